// File: rtl/rr_grant_encoder.sv
// Registered round-robin encoder: collapses an N-bit request vector into one fair binary grant index.
// Latency 1 cycle: req/enabler sampled at a load edge appear on out_idx/out_valid after that edge.
// Backpressure: while out_valid && !out_ready the grant is held stable and req/enabler are ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (clears grant, index and pointer)
//   req[N]     request vector, bit i = requester i wants a grant
//   enabler    permits new grants; a held grant is not affected
//   out_valid  out_idx holds an unconsumed grant
//   out_ready  downstream consumes the grant this cycle
//   out_idx[W] binary index of the granted requester, W = $clog2(N)
//   lock       (only with RR_ENCODER_LOCK_EN) keep the pointer on the accepted index
//
// Optional feature macro: RR_ENCODER_LOCK_EN adds the lock port.
module rr_grant_encoder #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enabler,
`ifdef RR_ENCODER_LOCK_EN
  input  logic         lock,
`endif
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] idx_nxt;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         accept;
  logic         load;
  logic         hold_ptr;

`ifdef RR_ENCODER_LOCK_EN
  assign hold_ptr = lock;
`else
  assign hold_ptr = 1'b0;
`endif

  assign out_valid = (state == FULL);
  assign accept    = out_valid && out_ready;
  assign load      = !out_valid || accept;

  // Pointer after this cycle. Wrap uses an explicit compare so non power-of-two
  // N never produces an out-of-range index.
  always_comb begin
    ptr_nxt = ptr;
    if (accept) begin
      if (hold_ptr)
        ptr_nxt = out_idx;
      else if (out_idx == W'(N-1))
        ptr_nxt = '0;
      else
        ptr_nxt = out_idx + W'(1);
    end
  end

  // Circular priority search. The search starts from the pointer value this
  // cycle's accept produces, so a grant consumed in the same cycle as a reload
  // is already excluded from top priority and back-to-back grants rotate.
  always_comb begin
    int           j;
    logic [W-1:0] jw;
    pick_idx = '0;
    pick_any = 1'b0;
    j        = 0;
    jw       = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_nxt) + i;
      if (j >= N)
        j = j - N;
      jw = W'(j);
      if (!pick_any && req[jw]) begin
        pick_any = 1'b1;
        pick_idx = jw;
      end
    end
  end

  // Next state / next index. Stalled cycles fall through with everything held.
  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    if (load) begin
      if (enabler && pick_any) begin
        state_nxt = FULL;
        idx_nxt   = pick_idx;
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      out_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= idx_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder (N=4 main instance, N=3 wrap instance).
module tb_rr_grant_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       enabler = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_idx;
`ifdef RR_ENCODER_LOCK_EN
  logic       lock = 1'b0;
`endif

  logic       reset3_n = 1'b0;
  logic [2:0] req3 = '0;
  logic       valid3;
  logic [1:0] idx3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_grant_encoder #(.N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .enabler   (enabler),
`ifdef RR_ENCODER_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  rr_grant_encoder #(.N(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset3_n),
    .req       (req3),
    .enabler   (1'b1),
`ifdef RR_ENCODER_LOCK_EN
    .lock      (1'b0),
`endif
    .out_ready (1'b1),
    .out_valid (valid3),
    .out_idx   (idx3)
  );

  // Advance one rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_vec++;
    if (out_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tick();
    req = 4'b1111; enabler = 1'b1; out_ready = 1'b1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== exp_seq[k]) begin
        n_err++;
        $display("FAIL fair[%0d] got v=%b idx=%0d exp v=1 idx=%0d", k, out_valid, out_idx, exp_seq[k]);
      end
    end
  endtask

  task automatic test_stall();
    req = 4'b0110;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
      n_err++; $display("FAIL stall_first got v=%b idx=%0d exp v=1 idx=1", out_valid, out_idx);
    end
    out_ready = 1'b0;
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b idx=%0d exp v=1 idx=1", k, out_valid, out_idx);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd3) begin
      n_err++; $display("FAIL stall_release got v=%b idx=%0d exp v=1 idx=3", out_valid, out_idx);
    end
  endtask

  task automatic test_wrap();
    req = 4'b0100;
    tick();
    n_vec++;
    if (out_idx !== 2'd2) begin n_err++; $display("FAIL wrap_setup got idx=%0d exp=2", out_idx); end
    req = 4'b0001;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
      n_err++; $display("FAIL wrap_grant got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx);
    end
    // Pointer must now be 1: with all requesting, index 1 wins next.
    req = 4'b1111;
    tick();
    n_vec++;
    if (out_idx !== 2'd1) begin n_err++; $display("FAIL wrap_ptr got idx=%0d exp=1", out_idx); end
  endtask

  task automatic test_wrap_n3();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
    req3 = 3'b111;
    reset3_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (valid3 !== 1'b1 || idx3 !== exp_seq[k]) begin
        n_err++; $display("FAIL n3[%0d] got v=%b idx=%0d exp v=1 idx=%0d", k, valid3, idx3, exp_seq[k]);
      end
    end
  endtask

  task automatic test_enable_empty();
    enabler = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_off[%0d] got v=%b exp=0", k, out_valid); end
    end
    enabler = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      n_err++; $display("FAIL en_on got v=%b idx=%0d exp v=1 idx=2", out_valid, out_idx);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid got v=%b exp=0", out_valid); end
    n_vec++;
    if (out_idx !== 2'd2) begin n_err++; $display("FAIL empty_idx_held got idx=%0d exp=2", out_idx); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req = 4'b0100;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      n_err++; $display("FAIL arst_setup got v=%b idx=%0d exp v=1 idx=2", out_valid, out_idx);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0) begin
      n_err++; $display("FAIL arst_immediate got v=%b idx=%0d exp v=0 idx=0", out_valid, out_idx);
    end
    tick();
    req = 4'b1111;
    out_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
      n_err++; $display("FAIL arst_first got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx);
    end
  endtask

`ifdef RR_ENCODER_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd2, 2'd2, 2'd3, 2'd0};
    req = 4'b0100;
    lock = 1'b0;
    tick();
    n_vec++;
    if (out_idx !== 2'd2) begin n_err++; $display("FAIL lock_setup got idx=%0d exp=2", out_idx); end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      lock = (k < 2);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== exp_seq[k]) begin
        n_err++; $display("FAIL lock[%0d] got v=%b idx=%0d exp v=1 idx=%0d", k, out_valid, out_idx, exp_seq[k]);
      end
    end
    lock = 1'b0;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_fairness();
    test_stall();
    test_wrap();
    test_enable_empty();
    test_async_reset();
`ifdef RR_ENCODER_LOCK_EN
    test_lock();
`endif
    test_wrap_n3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
